// File: rtl/mmu_pkg.sv
// Shared definitions for the 2x2 matrix-multiply datapath: default operand and
// accumulator widths, operand-mux select encodings and operand buffer addresses.
package mmu_pkg;

    localparam int DW = 8;
    localparam int AW = 16;

    localparam logic [1:0] SEL_0    = 2'd0;
    localparam logic [1:0] SEL_1    = 2'd1;
    localparam logic [1:0] SEL_ZERO = 2'd2;

    localparam logic [2:0] ADDR_W0 = 3'd0;
    localparam logic [2:0] ADDR_X0 = 3'd4;

endpackage

// File: rtl/mmu_pe.sv
// Multiply-accumulate processing element for the output-stationary 2x2 array.
// Forwards a and b one cycle downstream, multiplies them, and either restarts
// (clear) or extends its accumulator with the product.
// Build option: define MMU_SATURATE_EN to clamp the accumulator instead of
// letting it wrap modulo 2^AW.
module mmu_pe
    import mmu_pkg::*;
#(
    parameter int DW = mmu_pkg::DW,
    parameter int AW = mmu_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] a_out,
    output logic signed [DW-1:0] b_out,
    output logic signed [AW-1:0] acc
);

`ifdef MMU_SATURATE_EN
    function automatic logic signed [AW-1:0] sat_clip(input logic signed [AW:0] s);
        if (s[AW] != s[AW-1]) begin
            return s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end
        return s[AW-1:0];
    endfunction
`else
    function automatic logic signed [AW-1:0] wrap_add(input logic signed [AW-1:0] x,
                                                      input logic signed [AW-1:0] y);
        return x + y;
    endfunction
`endif

    logic signed [DW-1:0] a_p1;
    logic signed [DW-1:0] b_p1;
    logic signed [AW-1:0] acc_p1;
    logic signed [AW-1:0] a_ext;
    logic signed [AW-1:0] b_ext;
    logic signed [AW-1:0] prod;
    logic signed [AW-1:0] acc_next;

    // The product of two DW-bit operands fits in 2*DW <= AW bits, so an AW-wide
    // multiply of sign-extended operands is the sign-extended full product.
    assign a_ext = {{(AW-DW){a[DW-1]}}, a};
    assign b_ext = {{(AW-DW){b[DW-1]}}, b};
    assign prod  = a_ext * b_ext;

    // Next accumulator value: clear reloads with the product rather than zero
    always_comb begin
        acc_next = acc_p1;
`ifdef MMU_SATURATE_EN
        if (clear) begin
            acc_next = sat_clip({prod[AW-1], prod});
        end else begin
            acc_next = sat_clip({acc_p1[AW-1], acc_p1} + {prod[AW-1], prod});
        end
`else
        if (clear) begin
            acc_next = prod;
        end else begin
            acc_next = wrap_add(acc_p1, prod);
        end
`endif
    end

    // Stage p1: forwarding registers and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            a_p1   <= '0;
            b_p1   <= '0;
            acc_p1 <= '0;
        end else begin
            a_p1   <= a;
            b_p1   <= b;
            acc_p1 <= acc_next;
        end
    end

    assign a_out = a_p1;
    assign b_out = b_p1;
    assign acc   = acc_p1;

endmodule

// File: rtl/mmu_datapath.sv
// 2x2 signed matrix-multiply datapath: 8-entry operand buffer (A at 0-3,
// B at 4-7, both row-major), four select-driven operand muxes and a 2x2
// output-stationary systolic array of mmu_pe. Sequencing (selects, clear)
// is owned by the control unit; there is no handshake.
// Build option: MMU_SATURATE_EN selects saturating accumulation in the PEs.
module mmu_datapath
    import mmu_pkg::*;
#(
    parameter int DW = mmu_pkg::DW,
    parameter int AW = mmu_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    input  logic [2:0]           mem_addr,
    input  logic signed [DW-1:0] data_in,
    input  logic                 clear,
    input  logic [1:0]           a0_sel,
    input  logic [1:0]           a1_sel,
    input  logic [1:0]           b0_sel,
    input  logic [1:0]           b1_sel,
    output logic signed [AW-1:0] c00,
    output logic signed [AW-1:0] c01,
    output logic signed [AW-1:0] c10,
    output logic signed [AW-1:0] c11
);

    // Selects 2 and 3 inject zero so idle cycles leave the accumulators alone.
    function automatic logic signed [DW-1:0] op_mux(input logic [1:0]           sel,
                                                    input logic signed [DW-1:0] v0,
                                                    input logic signed [DW-1:0] v1);
        case (sel)
            SEL_0:   return v0;
            SEL_1:   return v1;
            default: return '0;
        endcase
    endfunction

    logic signed [DW-1:0] mem [0:7];
    logic signed [DW-1:0] a0;
    logic signed [DW-1:0] a1;
    logic signed [DW-1:0] b0;
    logic signed [DW-1:0] b1;
    logic signed [DW-1:0] a_fwd00;
    logic signed [DW-1:0] b_fwd00;
    logic signed [DW-1:0] a_fwd01;
    logic signed [DW-1:0] b_fwd01;
    logic signed [DW-1:0] a_fwd10;
    logic signed [DW-1:0] b_fwd10;
    logic signed [DW-1:0] a_fwd11;
    logic signed [DW-1:0] b_fwd11;
    logic                 unused_fwd;

    // Operand buffer write port; reads below see the pre-write contents
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
        end else if (load_en) begin
            mem[mem_addr] <= data_in;
        end
    end

    // A rows feed the left edge, B columns feed the top edge.
    assign a0 = op_mux(a0_sel, mem[ADDR_W0],        mem[ADDR_W0 + 3'd1]);
    assign a1 = op_mux(a1_sel, mem[ADDR_W0 + 3'd2], mem[ADDR_W0 + 3'd3]);
    assign b0 = op_mux(b0_sel, mem[ADDR_X0],        mem[ADDR_X0 + 3'd2]);
    assign b1 = op_mux(b1_sel, mem[ADDR_X0 + 3'd1], mem[ADDR_X0 + 3'd3]);

    mmu_pe #(.DW(DW), .AW(AW)) u_pe00 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .a     (a0),
        .b     (b0),
        .a_out (a_fwd00),
        .b_out (b_fwd00),
        .acc   (c00)
    );

    mmu_pe #(.DW(DW), .AW(AW)) u_pe01 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .a     (a_fwd00),
        .b     (b1),
        .a_out (a_fwd01),
        .b_out (b_fwd01),
        .acc   (c01)
    );

    mmu_pe #(.DW(DW), .AW(AW)) u_pe10 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .a     (a1),
        .b     (b_fwd00),
        .a_out (a_fwd10),
        .b_out (b_fwd10),
        .acc   (c10)
    );

    mmu_pe #(.DW(DW), .AW(AW)) u_pe11 (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .a     (a_fwd10),
        .b     (b_fwd01),
        .a_out (a_fwd11),
        .b_out (b_fwd11),
        .acc   (c11)
    );

    // Forwarding outputs at the right and bottom edges of the array go nowhere.
    assign unused_fwd = ^{a_fwd01, a_fwd11, b_fwd10, b_fwd11};

endmodule

// File: doc/mmu_datapath.md
# mmu_datapath

2x2 signed matrix-multiply datapath. It holds an 8-byte operand buffer (weights A, inputs B) and four select-driven operand muxes, and it contains a 2x2 output-stationary systolic array of multiply-accumulate PEs. The block sits directly under the control unit: it consumes `mem_addr`, `clear` and the four 2-bit selects, and returns the 16-bit results `c00..c11` that the control unit serializes onto `data_out`.

## Interface
- `DW`, 8: operand width (signed).
- `AW`, 16: accumulator/result width (signed).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `load_en`  in  1  write strobe for the operand buffer.
- `mem_addr`  in  3  operand buffer write address.
- `data_in`  in  DW  operand byte to write.
- `clear`  in  1  restart accumulation this cycle.
- `a0_sel`, `a1_sel`, `b0_sel`, `b1_sel`  in  2 each  operand mux selects.
- `c00`, `c01`, `c10`, `c11`  out  AW each  signed result registers.

## Operation
- **Operand buffer:** 8 x DW registers.
  - Addresses 0-3 hold w0..w3, which is A row-major: [w0 w1; w2 w3].
  - Addresses 4-7 hold x0..x3, which is B row-major: [x0 x1; x2 x3].
  - When `load_en`=1: `mem[mem_addr] <= data_in`.
- **Operand muxes** (combinational, read the registered buffer):
  - `a0`: sel 0->w0, 1->w1, 2/3->0.
  - `a1`: sel 0->w2, 1->w3, 2/3->0.
  - `b0`: sel 0->x0, 1->x2, 2/3->0.
  - `b1`: sel 0->x1, 1->x3, 2/3->0.
- **Array wiring:**
  - PE00 takes a=`a0`, b=`b0`.
  - PE01 takes a=PE00.a_out, b=`b1`.
  - PE10 takes a=`a1`, b=PE00.b_out.
  - PE11 takes a=PE10.a_out, b=PE01.b_out.
- **Each PE:**
  - Forwards its a and b to a_out and b_out through one register each, every cycle.
  - Computes a full signed product `p = a*b` (2*DW bits, sign-extended to AW).
  - If `clear`=1: `acc <= p` (restart; not zero).
  - Else: `acc <= acc + p`.
- **Arithmetic:** wraps modulo 2^AW by default (see Configuration).
- **Result:** C = A*B, with `cij` = `acc` of PEij.
- **Boundary conditions:**
  - Sel values 2 and 3 inject zero, which adds nothing.
  - A buffer write and a mux read of the same address in the same cycle return the old value. The new value is visible next cycle.
  - `clear` takes priority over accumulation in every PE. It does not affect the forwarding registers.
  - Reset mid-operation zeroes the buffer, the forwarding registers and the accumulators. The next `clear` starts a clean computation.
  - There is no ready/valid handshake; the control unit owns sequencing.

## Timing
- All outputs reset to 0. All state registers reset to 0.
- Let cycle k=0 be the cycle in which `clear`=1, using the schedule (sel values per cycle):
  - k=0: a0=0, a1=2, b0=0, b1=2.
  - k=1: all selects 1 except a1=0, b1=0.
  - k=2: a0=2, b0=2, a1=1, b1=1.
  - k>=3: all selects 2.
- `c00` is final after the edge ending k=1.
- `c01` and `c10` are final after the edge ending k=2.
- `c11` is final after the edge ending k=3.
- Results hold until the next `clear`, because zero operands keep accumulators stable.
- Latency from `clear` to the full result is 4 edges.

## Configuration
- `MMU_SATURATE_EN`
  - Defined: each accumulate computes at AW+1 bits and clamps to [-2^(AW-1), 2^(AW-1)-1]. The clear-load path is also clamped, which is a no-op for DW=8.
  - Undefined: two's-complement wrap modulo 2^AW.

## Structure
- Shared package `mmu_pkg` holds:
  - `DW` and `AW` defaults.
  - Select encodings: `SEL_0=2'd0`, `SEL_1=2'd1`, `SEL_ZERO=2'd2`.
  - Buffer address constants: `ADDR_W0=3'd0`, `ADDR_X0=3'd4`.
- One sub-module, `mmu_pe`: forwarding registers, multiplier, accumulator and the saturation option. It is instantiated four times.

## Test plan
- **Matrix product:** load A=[1 2;3 4], B=[5 6;7 8], then run the clear schedule -> c00=19, c01=22, c10=43, c11=50 at the stated edges.
- **Identity:** A=[1 0;0 1], B=[-5 6;7 -8] -> c=-5, 6, 7, -8. Outputs hold for 4 further idle cycles.
- **Overflow:** w0=w1=-128, x0=x2=-128 -> c00=0x8000 (-32768) without `MMU_SATURATE_EN`, and 32767 with it.
- **Re-clear:** a second schedule after loading A=[2 0;0 2] restarts accumulation -> c=2*B, with no residue from the prior run.
- **Write/read collision:** write w0=9 in cycle k=0 while a0_sel=0 -> k=0 uses the old w0 and the new value is used from k=1. All-sel=3 cycles add 0.
- **Reset mid-schedule:** assert `rst` at k=1 -> all c=0 next cycle. A fresh load and schedule then produce correct results.
